// File: rtl/ccd_readout_sequencer_if.sv
// Bundle of the sequencer's host, generator and ADC-side signals.
// The slave modport is the sequencer; the master modport is whoever drives it.
interface ccd_readout_sequencer_if #(
  parameter int unsigned IDX_W = 12
);
  logic             i_start;
  logic             i_stop;
  logic [3:0]       i_f_select;
  logic [7:0]       i_n_lines;
  logic             i_phi_p;
  logic             i_phi_l1;
  logic             i_adc_ready;
  logic             o_gen_enable;
  logic [3:0]       o_gen_f_select;
  logic             o_sample;
  logic [IDX_W-1:0] o_pixel_idx;
  logic             o_line_start;
  logic             o_line_done;
  logic [7:0]       o_line_cnt;
  logic             o_busy;
  logic             o_done;
  logic             o_overrun;

  modport master (
    output i_start, i_stop, i_f_select, i_n_lines, i_phi_p, i_phi_l1, i_adc_ready,
    input  o_gen_enable, o_gen_f_select, o_sample, o_pixel_idx, o_line_start,
           o_line_done, o_line_cnt, o_busy, o_done, o_overrun
  );

  modport slave (
    input  i_start, i_stop, i_f_select, i_n_lines, i_phi_p, i_phi_l1, i_adc_ready,
    output o_gen_enable, o_gen_f_select, o_sample, o_pixel_idx, o_line_start,
           o_line_done, o_line_cnt, o_busy, o_done, o_overrun
  );
endinterface

// File: rtl/ccd_readout_sequencer.sv
// Run-level controller for the CCD phase generator: starts/stops the generator,
// drops the undefined first line, turns L1 shift clocks into per-pixel ADC
// strobes and counts lines. Optional macro OVERRUN_DETECT_EN enables the sticky
// ADC overrun flag; without it o_overrun is 0 and i_adc_ready is ignored.
module ccd_readout_sequencer #(
  parameter int unsigned N_DUMMY  = 4,
  parameter int unsigned N_PIXELS = 2048,
  parameter int unsigned IDX_W    = 12
) (
  input logic                   i_clk,
  input logic                   i_rst,
  ccd_readout_sequencer_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StArm, StReadout} state_e;

  localparam logic [IDX_W-1:0] FirstPix = IDX_W'(N_DUMMY);
  localparam logic [IDX_W-1:0] EndPix   = IDX_W'(N_DUMMY + N_PIXELS);

  state_e           state_q, state_d;
  logic             phi_p_q, phi_l1_q;
  logic [IDX_W-1:0] shift_q, shift_d;
  logic [7:0]       n_lines_q, n_lines_d;
  logic             stop_pend_q, stop_pend_d;
  logic [3:0]       f_sel_q, f_sel_d;
  logic             sample_q, sample_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             line_start_q, line_start_d;
  logic             line_done_q, line_done_d;
  logic [7:0]       line_cnt_q, line_cnt_d;
  logic             done_q, done_d;
  logic             ovr_q, ovr_d;

  logic phi_p_rise, phi_p_fall, l1_rise, start_ok;

  assign phi_p_rise = bus.i_phi_p & ~phi_p_q;
  assign phi_p_fall = ~bus.i_phi_p & phi_p_q;
  assign l1_rise    = bus.i_phi_l1 & ~phi_l1_q;
  // A start landing on the o_done cycle is dropped: the run is still closing.
  assign start_ok   = (state_q == StIdle) && bus.i_start && !done_q;

  // Next-state and registered-output logic for the run FSM.
  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    n_lines_d    = n_lines_q;
    stop_pend_d  = stop_pend_q;
    f_sel_d      = f_sel_q;
    sample_d     = 1'b0;
    idx_d        = idx_q;
    line_start_d = 1'b0;
    line_done_d  = 1'b0;
    line_cnt_d   = line_cnt_q;
    done_d       = 1'b0;
    case (state_q)
      StIdle: begin
        if (start_ok) begin
          state_d     = StArm;
          f_sel_d     = bus.i_f_select;
          n_lines_d   = bus.i_n_lines;
          line_cnt_d  = 8'd0;
          stop_pend_d = 1'b0;
          shift_d     = '0;
        end
      end
      StArm: begin
        // L1 activity here belongs to the garbage line and is ignored.
        if (bus.i_stop) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end else if (phi_p_fall) begin
          state_d = StReadout;
          shift_d = '0;
        end
      end
      StReadout: begin
        if (bus.i_stop) stop_pend_d = 1'b1;
        if (l1_rise && !bus.i_phi_p) begin
          if (shift_q != '1) shift_d = shift_q + 1'b1;
          if (shift_q >= FirstPix && shift_q < EndPix) begin
            sample_d     = 1'b1;
            idx_d        = shift_q - FirstPix;
            line_start_d = (shift_q == FirstPix);
          end
        end
        if (phi_p_rise) begin
          line_done_d = 1'b1;
          line_cnt_d  = line_cnt_q + 8'd1;
          shift_d     = '0;
          if ((n_lines_q != 8'd0 && line_cnt_q + 8'd1 == n_lines_q) || stop_pend_q) begin
            state_d     = StIdle;
            done_d      = 1'b1;
            stop_pend_d = 1'b0;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

`ifdef OVERRUN_DETECT_EN
  // Sticky overrun: a strobe the ADC could not take; cleared by an accepted start.
  always_comb begin
    ovr_d = ovr_q;
    if (sample_q && !bus.i_adc_ready) ovr_d = 1'b1;
    if (start_ok) ovr_d = 1'b0;
  end
`else
  logic unused_adc_ready;
  assign unused_adc_ready = bus.i_adc_ready;
  assign ovr_d = 1'b0;
`endif

  // State and output registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= StIdle;
      phi_p_q      <= 1'b0;
      phi_l1_q     <= 1'b0;
      shift_q      <= '0;
      n_lines_q    <= 8'd0;
      stop_pend_q  <= 1'b0;
      f_sel_q      <= 4'd0;
      sample_q     <= 1'b0;
      idx_q        <= '0;
      line_start_q <= 1'b0;
      line_done_q  <= 1'b0;
      line_cnt_q   <= 8'd0;
      done_q       <= 1'b0;
      ovr_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      phi_p_q      <= bus.i_phi_p;
      phi_l1_q     <= bus.i_phi_l1;
      shift_q      <= shift_d;
      n_lines_q    <= n_lines_d;
      stop_pend_q  <= stop_pend_d;
      f_sel_q      <= f_sel_d;
      sample_q     <= sample_d;
      idx_q        <= idx_d;
      line_start_q <= line_start_d;
      line_done_q  <= line_done_d;
      line_cnt_q   <= line_cnt_d;
      done_q       <= done_d;
      ovr_q        <= ovr_d;
    end
  end

  assign bus.o_busy         = (state_q != StIdle);
  assign bus.o_gen_enable   = (state_q != StIdle);
  assign bus.o_gen_f_select = f_sel_q;
  assign bus.o_sample       = sample_q;
  assign bus.o_pixel_idx    = idx_q;
  assign bus.o_line_start   = line_start_q;
  assign bus.o_line_done    = line_done_q;
  assign bus.o_line_cnt     = line_cnt_q;
  assign bus.o_done         = done_q;
  assign bus.o_overrun      = ovr_q;

endmodule

// File: tb/tb_ccd_readout_sequencer.sv
// Bench for ccd_readout_sequencer: a generator model drives phase patterns, and
// each driven event schedules the outputs it must cause by cycle number.
module tb_ccd_readout_sequencer;
  localparam int NDummy = 4;
  localparam int NPix   = 2048;
  localparam int MIdle  = 0;
  localparam int MArm   = 1;
  localparam int MRead  = 2;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;

  ccd_readout_sequencer_if #(.IDX_W(12)) bus ();

  ccd_readout_sequencer #(.N_DUMMY(4), .N_PIXELS(2048), .IDX_W(12)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_pass = 0;

  // Expected pulses keyed by the cycle they must appear in.
  int exp_sample [int];
  bit exp_ld     [int];
  bit exp_done   [int];
  // Expected level changes keyed by the cycle they take effect.
  bit set_busy   [int];
  int set_lcnt   [int];
  int set_fsel   [int];
  bit set_ovr_clr[int];

  int m_st = MIdle, m_n = 0, m_lines = 0;
  bit m_stop = 0;
  bit m_busy = 0, m_ovr = 0, ovr_pend = 0;
  int m_lcnt = 0, m_fsel = 0;
  bit chk_en = 0;
  int dut_samples = 0;
  int drop_sample = -1;
  bit rand_drop = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
  endtask

  // Per-cycle comparison against the scheduled expectations.
  always @(negedge clk) begin
    if (chk_en) begin
      bit smp;
      if (ovr_pend) begin m_ovr = 1; ovr_pend = 0; end
      if (set_busy.exists(cyc)) m_busy = set_busy[cyc];
      if (set_lcnt.exists(cyc)) m_lcnt = set_lcnt[cyc];
      if (set_fsel.exists(cyc)) m_fsel = set_fsel[cyc];
      if (set_ovr_clr.exists(cyc)) m_ovr = 0;
      smp = exp_sample.exists(cyc);
      check("busy", 32'(bus.o_busy), 32'(m_busy));
      check("gen_enable", 32'(bus.o_gen_enable), 32'(m_busy));
      check("line_cnt", 32'(bus.o_line_cnt), 32'(m_lcnt));
      check("gen_f_select", 32'(bus.o_gen_f_select), 32'(m_fsel));
      check("sample", 32'(bus.o_sample), 32'(smp));
      if (smp) check("pixel_idx", 32'(bus.o_pixel_idx), 32'(exp_sample[cyc]));
      check("line_start", 32'(bus.o_line_start), 32'(smp ? (exp_sample[cyc] == 0) : 1'b0));
      check("line_done", 32'(bus.o_line_done), 32'(exp_ld.exists(cyc)));
      check("done", 32'(bus.o_done), 32'(exp_done.exists(cyc)));
      check("overrun", 32'(bus.o_overrun), 32'(m_ovr));
`ifdef OVERRUN_DETECT_EN
      if (smp && !bus.i_adc_ready) ovr_pend = 1;
`endif
      if (bus.o_sample === 1'b1) dut_samples++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int f, input int n);
    bus.i_start = 1; bus.i_f_select = 4'(f); bus.i_n_lines = 8'(n);
    if (m_st == MIdle && !exp_done.exists(cyc)) begin
      m_st = MArm; m_n = n; m_lines = 0; m_stop = 0;
      set_busy[cyc+1] = 1; set_lcnt[cyc+1] = 0; set_fsel[cyc+1] = f; set_ovr_clr[cyc+1] = 1;
    end
    tick();
    bus.i_start = 0;
  endtask

  task automatic do_stop();
    bus.i_stop = 1;
    if (m_st == MArm) begin
      exp_done[cyc+1] = 1; set_busy[cyc+1] = 0; m_st = MIdle;
    end else if (m_st == MRead) m_stop = 1;
    tick();
    bus.i_stop = 0;
  endtask

  task automatic do_reset();
    rst = 1;
    set_busy[cyc+1] = 0; set_lcnt[cyc+1] = 0; set_fsel[cyc+1] = 0; set_ovr_clr[cyc+1] = 1;
    m_st = MIdle; m_stop = 0;
    tick();
    rst = 0;
  endtask

  // One L1 shift clock (rise, then low); shift i counts from 0 within a line.
  task automatic shift_l1(input int i);
    bit drop;
    drop = 0;
    bus.i_phi_l1 = 1;
    if (m_st == MRead && i >= NDummy && i < NDummy + NPix) begin
      exp_sample[cyc+1] = i - NDummy;
      drop = (m_lines == 0 && i - NDummy == drop_sample) ||
             (rand_drop && $urandom_range(0, 63) == 0);
    end
    tick();
    if (drop) bus.i_adc_ready = 0;
    bus.i_phi_l1 = 0;
    tick();
    bus.i_adc_ready = 1;
  endtask

  task automatic p_rise();
    bus.i_phi_p = 1;
    if (m_st == MRead) begin
      m_lines = (m_lines + 1) % 256;
      exp_ld[cyc+1] = 1; set_lcnt[cyc+1] = m_lines;
      if ((m_n != 0 && m_lines == m_n) || m_stop) begin
        exp_done[cyc+1] = 1; set_busy[cyc+1] = 0; m_st = MIdle; m_stop = 0;
      end
    end
    tick();
  endtask

  task automatic p_fall();
    tick();
    bus.i_phi_p = 0;
    if (m_st == MArm) m_st = MRead;
    tick();
  endtask

  task automatic begin_run(input int f, input int n, input int garbage);
    do_start(f, n);
    for (int i = 0; i < garbage; i++) shift_l1(i);
    p_rise();
    p_fall();
  endtask

  task automatic run_line(input int nsh, input int stop_at);
    for (int i = 0; i < nsh; i++) begin
      if (i == stop_at) do_stop();
      shift_l1(i);
    end
    p_rise();
    p_fall();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end

  initial begin
    int nl, len;
    rst = 1;
    bus.i_start = 0; bus.i_stop = 0; bus.i_f_select = 0; bus.i_n_lines = 0;
    bus.i_phi_p = 0; bus.i_phi_l1 = 0; bus.i_adc_ready = 1;
    repeat (3) @(posedge clk);
    #1;
    rst = 0;
    chk_en = 1;
    check("reset_busy", 32'(bus.o_busy), 32'd0);
    check("reset_gen_enable", 32'(bus.o_gen_enable), 32'd0);
    check("reset_line_cnt", 32'(bus.o_line_cnt), 32'd0);
    check("reset_pixel_idx", 32'(bus.o_pixel_idx), 32'd0);
    check("reset_overrun", 32'(bus.o_overrun), 32'd0);

    // Two full lines with extra shifts; a busy start with a new f_select is ignored.
    tick();
    dut_samples = 0;
    drop_sample = 100;
    begin_run(3, 2, 3);
    for (int i = 0; i < NDummy + NPix + 5; i++) begin
      if (i == 1000) do_start(9, 5);
      shift_l1(i);
    end
    p_rise();
    p_fall();
    run_line(NDummy + NPix, -1);
    drop_sample = -1;
    check("runA_samples", 32'(dut_samples), 32'd4096);
    check("runA_line_cnt", 32'(bus.o_line_cnt), 32'd2);
    check("runA_f_select", 32'(bus.o_gen_f_select), 32'd3);
    check("runA_gen_enable", 32'(bus.o_gen_enable), 32'd0);
`ifdef OVERRUN_DETECT_EN
    check("runA_overrun", 32'(bus.o_overrun), 32'd1);
`else
    check("runA_overrun", 32'(bus.o_overrun), 32'd0);
`endif

    // Stop while discarding the garbage line.
    tick();
    do_start(5, 0);
    shift_l1(0);
    shift_l1(1);
    do_stop();
    check("armstop_done", 32'(bus.o_done), 32'd1);
    check("armstop_line_cnt", 32'(bus.o_line_cnt), 32'd0);
    check("armstop_overrun", 32'(bus.o_overrun), 32'd0);
    tick();

    // Continuous run stopped during line 5.
    begin_run($urandom_range(0, 15), 0, $urandom_range(0, 4));
    nl = 0;
    while (m_st == MRead && nl < 10) begin
      len = $urandom_range(1, 40);
      run_line(len, (nl == 4) ? $urandom_range(0, len - 1) : -1);
      nl++;
    end
    check("stop_line_cnt", 32'(bus.o_line_cnt), 32'd5);
    tick();

    // Reset in the middle of a readout line, then a normal run.
    begin_run($urandom_range(0, 15), 3, 2);
    run_line(20, -1);
    for (int i = 0; i < 10; i++) shift_l1(i);
    do_reset();
    check("midrst_busy", 32'(bus.o_busy), 32'd0);
    check("midrst_gen_enable", 32'(bus.o_gen_enable), 32'd0);
    check("midrst_line_cnt", 32'(bus.o_line_cnt), 32'd0);
    check("midrst_f_select", 32'(bus.o_gen_f_select), 32'd0);
    check("midrst_pixel_idx", 32'(bus.o_pixel_idx), 32'd0);
    tick();

    // Long then short line; a start on the o_done cycle is ignored.
    begin_run($urandom_range(0, 15), 2, 1);
    run_line(NDummy + NPix + 8, -1);
    for (int i = 0; i < 30; i++) shift_l1(i);
    p_rise();
    do_start(7, 1);
    p_fall();
    check("donestart_busy", 32'(bus.o_busy), 32'd0);
    check("donestart_line_cnt", 32'(bus.o_line_cnt), 32'd2);
    tick();

    // Randomized short runs with occasional stops and ADC stalls.
    rand_drop = 1;
    for (int r = 0; r < 4; r++) begin
      begin_run($urandom_range(0, 15), $urandom_range(1, 4), $urandom_range(0, 5));
      nl = 0;
      while (m_st == MRead && nl < 8) begin
        len = $urandom_range(1, 60);
        run_line(len, ($urandom_range(0, 3) == 0) ? $urandom_range(0, len - 1) : -1);
        nl++;
      end
      repeat ($urandom_range(1, 4)) tick();
    end
    repeat (4) tick();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
